// File: rtl/sync_pkg.sv
// Shared constants, helpers and types for the async-input conditioner.
package sync_pkg;

  // Fewest synchronizer flops that still give a usable MTBF.
  localparam int STAGES_MIN = 2;

  // Filter counter width: must hold 0..filt-1, never narrower than one bit.
  function automatic int sync_cnt_w(int filt);
    int w;
    w = $clog2(filt + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Per-channel result bundle collected by the top level.
  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } ch_out_t;

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: N-flop synchronizer, optional stability filter, edge history.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_CYC = 0,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_an_i,
  input  logic d_i,
  output logic d_o,
  output logic rise_o,
  output logic fall_o
);

  if (STAGES < STAGES_MIN) begin : g_bad_stages
    $error("sync_filt_ch: STAGES must be >= 2");
  end

  // Pure flop chain; nothing may sit between these flops.
  (* async_reg = "true" *) logic [STAGES-1:0] sync_q;
  logic sync_s;
  logic lvl;
  logic hist_q;

  // Shift the raw input through the synchronizer.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) sync_q <= {STAGES{RST_VAL}};
    else           sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign sync_s = sync_q[STAGES-1];

  if (FILT_CYC == 0) begin : g_nofilt
    assign lvl = sync_s;
  end else begin : g_filt
    localparam int CNT_W = sync_cnt_w(FILT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;

    // Accept a new level only after it has differed for FILT_CYC straight cycles;
    // any return to the current level discards the partial count.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
        cnt_q <= '0;
        lvl_q <= RST_VAL;
      end else if (sync_s == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        lvl_q <= sync_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign lvl = lvl_q;
  end

  // Remember last cycle's output level; reset matches d_o so release is pulse-free.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) hist_q <= RST_VAL;
    else           hist_q <= lvl;
  end

  assign d_o    = lvl;
  assign rise_o = lvl & ~hist_q;
  assign fall_o = ~lvl & hist_q;

endmodule

// File: rtl/sync_filt_edge.sv
// Multi-bit async-input conditioner: independent per-bit sync, filter, edge detect.
module sync_filt_edge
  import sync_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = 2,
  parameter int               FILT_CYC = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  ch_out_t [WIDTH-1:0] ch_out;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filt_ch #(
      .STAGES  (STAGES),
      .FILT_CYC(FILT_CYC),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_an_i(rst_an_i),
      .d_i     (d_i[i]),
      .d_o     (ch_out[i].lvl),
      .rise_o  (ch_out[i].rise),
      .fall_o  (ch_out[i].fall)
    );

    assign d_o[i]    = ch_out[i].lvl;
    assign rise_o[i] = ch_out[i].rise;
    assign fall_o[i] = ch_out[i].fall;
  end

  // Any edge on any bit this cycle.
  assign chg_o = |(rise_o | fall_o);

endmodule
